// File: rtl/dmem_mmio.sv
// Data memory stage: word-addressed RAM plus button, frame-tick timer and LFSR peripherals.
// Optional LED register at 0x1014 when DMEM_MMIO_LED_EN is defined.
`timescale 1ns/1ps
module dmem_mmio #(
   parameter int unsigned RAM_WORDS = 256,
   parameter int unsigned TICK_DIV  = 50000,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   input  logic        btn_in,
`ifdef DMEM_MMIO_LED_EN
   output logic [7:0]  led,
`endif
   output logic        tick
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   localparam logic [29:0] A_BTN   = 30'h400;
   localparam logic [29:0] A_EDGE  = 30'h401;
   localparam logic [29:0] A_TIMER = 30'h402;
   localparam logic [29:0] A_TFLAG = 30'h403;
   localparam logic [29:0] A_RAND  = 30'h404;
   localparam logic [29:0] A_LED   = 30'h405;

   logic [31:0]   mem [RAM_WORDS];
   logic [29:0]   word_addr;
   logic          ram_sel;
   logic [AW-1:0] ram_idx;
   logic          unused_addr_bits;

   logic          btn_s1_q, btn_sync_q, btn_prev_q, edge_q, edge_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [31:0]   timer_q, timer_d;
   logic          tflag_q, tflag_d, tick_q, wrap;
   logic [31:0]   lfsr_q, lfsr_d;

   assign word_addr        = addr[31:2];
   assign ram_sel          = (addr[31:12] == 20'd0);
   assign ram_idx          = addr[AW+1:2];
   assign unused_addr_bits = ^addr[1:0];
   assign tick             = tick_q;

   always_ff @(posedge clk) begin
      if (mem_write && ram_sel) mem[ram_idx] <= write_data;
   end

   always_comb begin
      wrap  = (pre_q == PRE_LAST);
      pre_d = wrap ? '0 : pre_q + PW'(1);

      // A rising edge arriving on the clearing cycle must not be lost.
      edge_d = (btn_sync_q & ~btn_prev_q)
             | (edge_q & ~(mem_read && word_addr == A_EDGE));

      timer_d = timer_q;
      if (mem_write && word_addr == A_TIMER) timer_d = write_data;
      else if (wrap)                         timer_d = timer_q + 32'd1;

      tflag_d = wrap | (tflag_q & ~(mem_write && word_addr == A_TFLAG));

      lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      if (mem_write && word_addr == A_RAND)
         lfsr_d = (write_data == 32'd0) ? LFSR_SEED : write_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_s1_q   <= 1'b0;
         btn_sync_q <= 1'b0;
         btn_prev_q <= 1'b0;
         edge_q     <= 1'b0;
         pre_q      <= '0;
         timer_q    <= '0;
         tflag_q    <= 1'b0;
         tick_q     <= 1'b0;
         lfsr_q     <= LFSR_SEED;
      end else begin
         btn_s1_q   <= btn_in;
         btn_sync_q <= btn_s1_q;
         btn_prev_q <= btn_sync_q;
         edge_q     <= edge_d;
         pre_q      <= pre_d;
         timer_q    <= timer_d;
         tflag_q    <= tflag_d;
         tick_q     <= wrap;
         lfsr_q     <= lfsr_d;
      end
   end

`ifdef DMEM_MMIO_LED_EN
   logic [7:0] led_q;
   assign led = led_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 led_q <= '0;
      else if (mem_write && word_addr == A_LED)  led_q <= write_data[7:0];
   end
`endif

   always_comb begin
      read_data = '0;
      if (ram_sel) begin
         read_data = mem[ram_idx];
      end else begin
         case (word_addr)
            A_BTN:   read_data = {31'b0, btn_sync_q};
            A_EDGE:  read_data = {31'b0, edge_q};
            A_TIMER: read_data = timer_q;
            A_TFLAG: read_data = {31'b0, tflag_q};
            A_RAND:  read_data = lfsr_q;
`ifdef DMEM_MMIO_LED_EN
            A_LED:   read_data = {24'b0, led_q};
`endif
            default: read_data = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: RAM, button edge flag, tick timer and LFSR.
`timescale 1ns/1ps
module tb_dmem_mmio;
   localparam int          TD   = 4;
   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic        clk = 1'b0;
   logic        reset, mem_write, mem_read, btn_in, tick;
   logic [31:0] addr, write_data, read_data;

   int total = 0;
   int bad   = 0;
   int cyc;
   logic [31:0] ram_m [256];
   bit          ram_v [256];
   logic [31:0] lfsr_base;
   int          lfsr_c0;
   int          timer_c0;

   dmem_mmio #(.RAM_WORDS(256), .TICK_DIV(TD), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
      .addr(addr), .write_data(write_data), .read_data(read_data),
      .btn_in(btn_in), .tick(tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
   endfunction

   function automatic logic [31:0] lfsr_exp();
      logic [31:0] v = lfsr_base;
      for (int i = 0; i < cyc - lfsr_c0; i++) v = lfsr_step(v);
      return v;
   endfunction

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] a_t [5];
      logic [31:0] e_t [5];
      a_t = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
      e_t = '{32'h0, 32'h0, 32'h0, 32'h0, SEED};
      reset = 1; mem_write = 0; mem_read = 0; btn_in = 0; addr = 0; write_data = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         addr = a_t[i]; #1;
         total++;
         if (read_data !== e_t[i]) begin
            bad++; $display("FAIL reset_reg addr=%h got=%h exp=%h", a_t[i], read_data, e_t[i]);
         end
      end
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
      @(posedge clk); #1;
      reset = 0;
      lfsr_base = SEED; lfsr_c0 = 0; timer_c0 = 0;
   endtask

   task automatic test_lfsr_free();
      addr = 32'h1010; #1;
      total++;
      if (read_data !== SEED) begin bad++; $display("FAIL rand_seed got=%h exp=%h", read_data, SEED); end
      nxt();
      total++;
      if (read_data !== lfsr_step(SEED)) begin
         bad++; $display("FAIL rand_step got=%h exp=%h", read_data, lfsr_step(SEED));
      end
   endtask

   task automatic test_timer();
      total++;
      if (tick !== (cyc % TD == 0)) begin bad++; $display("FAIL tick_pulse cyc=%0d got=%b", cyc, tick); end
      while (cyc < 13) begin
         nxt();
         total++;
         if (tick !== (cyc % TD == 0)) begin bad++; $display("FAIL tick_pulse cyc=%0d got=%b", cyc, tick); end
      end
      addr = 32'h1008; #1;
      total++;
      if (read_data !== 32'd3) begin bad++; $display("FAIL timer_count got=%h exp=3", read_data); end
      addr = 32'h100C; #1;
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL tflag_set got=%h exp=1", read_data); end
      mem_write = 1; write_data = $urandom;
      nxt();
      mem_write = 0; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL tflag_clear got=%h exp=0", read_data); end
   endtask

   task automatic test_timer_wrap();
      while (cyc % TD != TD - 1) nxt();
      mem_write = 1; addr = 32'h1008; write_data = 32'hFFFF_FFFF;
      nxt();
      mem_write = 0; #1;
      total++;
      if (tick !== 1'b1) begin bad++; $display("FAIL wrap_tick got=%b exp=1", tick); end
      total++;
      if (read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_load_wins got=%h exp=ffffffff", read_data); end
      repeat (TD - 1) nxt();
      total++;
      if (read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_hold got=%h exp=ffffffff", read_data); end
      nxt();
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL timer_rollover got=%h exp=0", read_data); end
      timer_c0 = cyc;
   endtask

   task automatic test_tflag_set_wins();
      addr = 32'h100C;
      while (cyc % TD != 1) nxt();
      mem_write = 1; nxt(); mem_write = 0; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL tflag_clear2 got=%h exp=0", read_data); end
      while (cyc % TD != TD - 1) nxt();
      mem_write = 1; nxt(); mem_write = 0; #1;
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL tflag_set_wins got=%h exp=1", read_data); end
   endtask

   task automatic test_lfsr_load();
      logic [31:0] v, e;
      addr = 32'h1010; mem_write = 1; write_data = 32'd0;
      nxt(); mem_write = 0; #1;
      total++;
      if (read_data !== SEED) begin bad++; $display("FAIL rand_zero_load got=%h exp=%h", read_data, SEED); end
      mem_write = 1; write_data = 32'd1;
      nxt(); mem_write = 0; #1;
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL rand_load_one got=%h exp=1", read_data); end
      for (int i = 0; i < 10; i++) begin
         v = $urandom;
         if ($urandom_range(3) == 0) v = 32'd0;
         mem_write = 1; write_data = v;
         nxt(); mem_write = 0; #1;
         lfsr_base = (v == 32'd0) ? SEED : v; lfsr_c0 = cyc;
         repeat ($urandom_range(3)) nxt();
         e = lfsr_exp();
         total++;
         if (read_data !== e) begin bad++; $display("FAIL rand_random got=%h exp=%h", read_data, e); end
      end
   endtask

   task automatic test_ram();
      int idx;
      mem_write = 1; addr = 32'h004; write_data = 32'hDEAD_BEEF;
      nxt(); mem_write = 0; #1;
      ram_m[1] = 32'hDEAD_BEEF; ram_v[1] = 1;
      total++;
      if (read_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", read_data); end
      addr = 32'h404; #1;
      total++;
      if (read_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", read_data); end
      mem_write = 1; addr = 32'h008; write_data = 32'h12;
      nxt(); mem_write = 0; #1;
      ram_m[2] = 32'h12; ram_v[2] = 1;
      total++;
      if (read_data !== 32'h12) begin bad++; $display("FAIL ram_rd2 got=%h exp=12", read_data); end
      addr = 32'h004; mem_write = 1; write_data = 32'hCAFE_F00D; #1;
      total++;
      if (read_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd_old got=%h exp=deadbeef", read_data); end
      nxt(); mem_write = 0; #1;
      ram_m[1] = 32'hCAFE_F00D;
      total++;
      if (read_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL ram_rd_new got=%h exp=cafef00d", read_data); end
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(255);
         addr = {20'd0, 2'($urandom), 8'(idx), 2'b00};
         write_data = $urandom; mem_write = 1;
         ram_m[idx] = write_data; ram_v[idx] = 1;
         nxt();
      end
      mem_write = 0;
      for (int i = 0; i < 256; i++) begin
         if (ram_v[i]) begin
            addr = {20'd0, 2'($urandom), 8'(i), 2'($urandom)}; #1;
            total++;
            if (read_data !== ram_m[i]) begin
               bad++; $display("FAIL ram_random addr=%h got=%h exp=%h", addr, read_data, ram_m[i]);
            end
            nxt();
         end
      end
      mem_write = 1; addr = 32'h2004; write_data = 32'h0BAD_0BAD;
      nxt(); mem_write = 0;
      addr = 32'h004; #1;
      total++;
      if (read_data !== ram_m[1]) begin bad++; $display("FAIL ram_unmapped_wr got=%h exp=%h", read_data, ram_m[1]); end
      addr = 32'h2004; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", read_data); end
      addr = 32'h1014; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL led_off_rd got=%h exp=0", read_data); end
   endtask

   task automatic test_button();
      btn_in = 0; mem_read = 0; addr = 32'h1000;
      repeat (3) nxt();
      btn_in = 1; nxt();
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL btn_sync1 got=%h exp=0", read_data); end
      nxt();
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL btn_sync2 got=%h exp=1", read_data); end
      addr = 32'h1004; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL edge_early got=%h exp=0", read_data); end
      nxt();
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL edge_3rd got=%h exp=1", read_data); end
      nxt(); mem_read = 1; #1;
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL edge_load got=%h exp=1", read_data); end
      nxt(); mem_read = 0; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL edge_cleared got=%h exp=0", read_data); end
      btn_in = 0;
      repeat (3) nxt();
      btn_in = 1; nxt(); btn_in = 0; nxt(); nxt();
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL edge_pulse got=%h exp=1", read_data); end
      btn_in = 1; nxt(); btn_in = 0; nxt();
      mem_read = 1;
      nxt(); mem_read = 0; #1;
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL edge_set_wins got=%h exp=1", read_data); end
      mem_read = 1;
      nxt(); mem_read = 0; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL edge_clear2 got=%h exp=0", read_data); end
   endtask

   task automatic test_async_reset();
      logic [31:0] et;
      btn_in = 1; addr = 32'h1004;
      repeat (4) nxt();
      while (cyc % TD != 0) nxt();
      total++;
      if (read_data !== 32'd1) begin bad++; $display("FAIL pre_rst_edge got=%h exp=1", read_data); end
      total++;
      if (tick !== 1'b1) begin bad++; $display("FAIL pre_rst_tick got=%b exp=1", tick); end
      addr = 32'h1008; #1;
      et = 32'((cyc - timer_c0) / TD);
      total++;
      if (read_data !== et) begin bad++; $display("FAIL pre_rst_timer got=%h exp=%h", read_data, et); end
      #1 reset = 1; #1;
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", tick); end
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL rst_timer got=%h exp=0", read_data); end
      addr = 32'h1004; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL rst_edge got=%h exp=0", read_data); end
      addr = 32'h100C; #1;
      total++;
      if (read_data !== 32'd0) begin bad++; $display("FAIL rst_tflag got=%h exp=0", read_data); end
      addr = 32'h1010; #1;
      total++;
      if (read_data !== SEED) begin bad++; $display("FAIL rst_rand got=%h exp=%h", read_data, SEED); end
      addr = 32'h004; #1;
      total++;
      if (read_data !== ram_m[1]) begin bad++; $display("FAIL rst_ram_kept got=%h exp=%h", read_data, ram_m[1]); end
      @(posedge clk); #1;
      reset = 0; btn_in = 0;
      repeat (2) nxt();
   endtask

   initial begin
      test_reset();
      test_lfsr_free();
      test_timer();
      test_timer_wrap();
      test_tflag_set_wins();
      test_lfsr_load();
      test_ram();
      test_button();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
